des_permutation_unit: RTL and testbench



---
 rtl/des_perm_pkg.sv | 47 ++++
 rtl/des_perm_stage.sv | 32 +++
 rtl/des_permutation_unit.sv | 104 ++++++++++
 tb/tb_des_permutation_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_perm_pkg.sv
// Shared constants for the DES permutation unit: FIPS 46 IP/FP tables,
// MODE encodings and the table-driven permute helper.
package des_perm_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  localparam logic [1:0] MODE_IP = 2'b00;
  localparam logic [1:0] MODE_FP = 2'b01;
  localparam logic [1:0] MODE_ID = 2'b10;

  // Entry n holds the 1-based source bit for output bit n.
  typedef int perm_table_t [1:64];

  localparam perm_table_t IP_TABLE = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam perm_table_t FP_TABLE = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [64:1] permute(input logic [64:1] data,
                                          input perm_table_t tbl);
    logic [64:1] result;
    result = '0;
    for (int n = 1; n <= DATA_W; n++) begin
      result[7'(n)] = data[7'(tbl[7'(n)])];
    end
    return result;
  endfunction

endpackage

// File: rtl/des_perm_stage.sv
// One pipeline slice: valid flag plus data/tag registers, loaded when the
// surrounding chain says this slice may take a new entry.
module des_perm_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             src_valid,
  input  logic [64:1]      src_data,
  input  logic [TAG_W-1:0] src_tag,
  output logic             valid,
  output logic [64:1]      data,
  output logic [TAG_W-1:0] tag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= src_valid;
      // Payload only moves with a real block so a drained slice keeps its last contents.
      if (src_valid) begin
        data <= src_data;
        tag  <= src_tag;
      end
    end
  end

endmodule

// File: rtl/des_permutation_unit.sv
// Pipelined DES IP/FP/identity permutation with valid/ready flow control.
// Define DES_PERM_TRISTATE_EN to float LEFT/RIGHT/TAG_OUT while OUT_VALID is low.
module des_permutation_unit
  import des_perm_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CHIP_SELECT_BAR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       MODE,
  input  logic [TAG_W-1:0] TAG_IN,
  input  logic [64:1]      DATA_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [32:1]      LEFT,
  output logic [32:1]      RIGHT,
  output logic [TAG_W-1:0] TAG_OUT,
  output logic             BUSY
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("des_permutation_unit: STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("des_permutation_unit: TAG_W must be at least 1");
  end

  // Handshake: a transfer happens on a rising CLK edge where valid and ready
  // are both high; valid never waits on ready, and a held block keeps its
  // payload stable until it transfers.

  logic [STAGES:1]  stage_valid;
  logic [STAGES:1]  stage_load;
  logic [64:1]      stage_data [1:STAGES];
  logic [TAG_W-1:0] stage_tag  [1:STAGES];
  logic [64:1]      permuted;

  always_comb begin
    permuted = DATA_IN;
    case (MODE)
      MODE_IP: permuted = permute(DATA_IN, IP_TABLE);
      MODE_FP: permuted = permute(DATA_IN, FP_TABLE);
      default: permuted = DATA_IN;
    endcase
  end

  // Ready ripples back from the output so a full pipeline still streams.
  always_comb begin
    stage_load = '0;
    stage_load[STAGES] = !stage_valid[STAGES] || OUT_READY;
    for (int k = STAGES - 1; k >= 1; k--) begin
      stage_load[k] = !stage_valid[k] || stage_load[k+1];
    end
  end

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    logic             src_valid;
    logic [64:1]      src_data;
    logic [TAG_W-1:0] src_tag;

    if (g == 1) begin : g_head
      assign src_valid = IN_VALID && !CHIP_SELECT_BAR;
      assign src_data  = permuted;
      assign src_tag   = TAG_IN;
    end else begin : g_body
      assign src_valid = stage_valid[g-1];
      assign src_data  = stage_data[g-1];
      assign src_tag   = stage_tag[g-1];
    end

    des_perm_stage #(
      .TAG_W(TAG_W)
    ) u_stage (
      .clk      (CLK),
      .rst      (RESET),
      .load     (stage_load[g]),
      .src_valid(src_valid),
      .src_data (src_data),
      .src_tag  (src_tag),
      .valid    (stage_valid[g]),
      .data     (stage_data[g]),
      .tag      (stage_tag[g])
    );
  end

  assign IN_READY  = !CHIP_SELECT_BAR && stage_load[1];
  assign OUT_VALID = stage_valid[STAGES];
  assign BUSY      = |stage_valid;

`ifdef DES_PERM_TRISTATE_EN
  assign LEFT    = OUT_VALID ? stage_data[STAGES][32:1]  : 'z;
  assign RIGHT   = OUT_VALID ? stage_data[STAGES][64:33] : 'z;
  assign TAG_OUT = OUT_VALID ? stage_tag[STAGES]         : 'z;
`else
  assign LEFT    = stage_data[STAGES][32:1];
  assign RIGHT   = stage_data[STAGES][64:33];
  assign TAG_OUT = stage_tag[STAGES];
`endif

endmodule

// File: tb/tb_des_permutation_unit.sv
// Directed bench for des_permutation_unit: a STAGES=2 and a STAGES=3 instance
// share clock and reset; each task drives one scenario and checks inline.
module tb_des_permutation_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

`ifdef DES_PERM_TRISTATE_EN
  logic [31:0] exp_lr  = 32'hzzzz_zzzz;
  logic [3:0]  exp_trs = 4'hz;
`else
  logic [31:0] exp_lr  = 32'h0;
  logic [3:0]  exp_trs = 4'h0;
`endif

  logic        csb2, iv2, irdy2, ov2, ordy2, busy2;
  logic [1:0]  mode2;
  logic [3:0]  tag2, tago2;
  logic [64:1] din2;
  logic [32:1] left2, right2;

  logic        csb3, iv3, irdy3, ov3, ordy3, busy3;
  logic [1:0]  mode3;
  logic [3:0]  tag3, tago3;
  logic [64:1] din3;
  logic [32:1] left3, right3;

  des_permutation_unit #(.STAGES(2), .TAG_W(4)) u2 (
    .CLK(clk), .RESET(rst), .CHIP_SELECT_BAR(csb2), .IN_VALID(iv2),
    .IN_READY(irdy2), .MODE(mode2), .TAG_IN(tag2), .DATA_IN(din2),
    .OUT_VALID(ov2), .OUT_READY(ordy2), .LEFT(left2), .RIGHT(right2),
    .TAG_OUT(tago2), .BUSY(busy2)
  );

  des_permutation_unit #(.STAGES(3), .TAG_W(4)) u3 (
    .CLK(clk), .RESET(rst), .CHIP_SELECT_BAR(csb3), .IN_VALID(iv3),
    .IN_READY(irdy3), .MODE(mode3), .TAG_IN(tag3), .DATA_IN(din3),
    .OUT_VALID(ov3), .OUT_READY(ordy3), .LEFT(left3), .RIGHT(right3),
    .TAG_OUT(tago3), .BUSY(busy3)
  );

  // Row/column closed form of the FIPS 46 IP table.
  function automatic int ip_src(input int n);
    int r, c;
    r = (n - 1) / 8;
    c = (n - 1) % 8;
    return (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
  endfunction

  function automatic logic [64:1] ip_model(input logic [64:1] d);
    logic [64:1] o;
    o = '0;
    for (int n = 1; n <= 64; n++) o[7'(n)] = d[7'(ip_src(n))];
    return o;
  endfunction

  function automatic logic [64:1] fp_model(input logic [64:1] d);
    logic [64:1] o;
    o = '0;
    for (int n = 1; n <= 64; n++) o[7'(ip_src(n))] = d[7'(n)];
    return o;
  endfunction

  function automatic logic [64:1] model(input logic [1:0] m, input logic [64:1] d);
    case (m)
      2'b00:   return ip_model(d);
      2'b01:   return fp_model(d);
      default: return d;
    endcase
  endfunction

  function automatic logic [64:1] blk_data(input int k);
    return {32'(k) * 32'h9E37_79B9, 32'(k) ^ 32'hA5A5_0F0F};
  endfunction

  logic [64:1] feed_q[$];
  logic [64:1] got_q[$];
  logic [3:0]  got_tag_q[$];
  logic [67:0] exp_q[$];

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send2(input logic [64:1] d, input logic [1:0] m, input logic [3:0] t);
    int waited;
    iv2 = 1'b1; din2 = d; mode2 = m; tag2 = t; waited = 0;
    forever begin
      @(negedge clk);
      if (irdy2) begin
        @(posedge clk); #1;
        iv2 = 1'b0;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL send2_timeout: accepted=0 required=1");
        iv2 = 1'b0;
        break;
      end
    end
  endtask

  task automatic send3(input logic [64:1] d, input logic [1:0] m, input logic [3:0] t);
    int waited;
    iv3 = 1'b1; din3 = d; mode3 = m; tag3 = t; waited = 0;
    forever begin
      @(negedge clk);
      if (irdy3) begin
        @(posedge clk); #1;
        iv3 = 1'b0;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL send3_timeout: accepted=0 required=1");
        iv3 = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ov2 !== 1'b0)   begin bad++; $display("FAIL rst_ov2: got=%b exp=0", ov2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy2: got=%b exp=0", busy2); end
    total++; if (left2 !== exp_lr)  begin bad++; $display("FAIL rst_left2: got=%h exp=%h", left2, exp_lr); end
    total++; if (right2 !== exp_lr) begin bad++; $display("FAIL rst_right2: got=%h exp=%h", right2, exp_lr); end
    total++; if (tago2 !== exp_trs) begin bad++; $display("FAIL rst_tag2: got=%h exp=%h", tago2, exp_trs); end
    total++; if (ov3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL rst_u3: ov=%b busy=%b exp=0,0", ov3, busy3); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL rst_irdy2: got=%b exp=1", irdy2); end
    total++; if (irdy3 !== 1'b1) begin bad++; $display("FAIL rst_irdy3: got=%b exp=1", irdy3); end
  endtask

  task automatic test_single_bit;
    int          idx_t [6] = '{58, 40, 7, 1, 1, 33};
    logic [1:0]  mode_t[6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [31:0] el_t  [6] = '{32'h1, 32'h1, 32'h40, 32'h0, 32'h0, 32'h0};
    logic [31:0] er_t  [6] = '{32'h0, 32'h0, 32'h0, 32'h80, 32'h0200_0000, 32'h1};
    logic [64:1] d;
    logic [3:0]  t;
    @(posedge clk); #1;
    ordy2 = 1'b1;
    for (int v = 0; v < 6; v++) begin
      d = '0;
      d[7'(idx_t[v])] = 1'b1;
      t = 4'(v + 5);
      send2(d, mode_t[v], t);
      total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL bit%0d_early: ov=%b exp=0", v, ov2); end
      @(posedge clk); #1;
      total++; if (ov2 !== 1'b1) begin bad++; $display("FAIL bit%0d_ov: got=%b exp=1", v, ov2); end
      total++; if (left2 !== el_t[v]) begin bad++; $display("FAIL bit%0d_left: got=%h exp=%h", v, left2, el_t[v]); end
      total++; if (right2 !== er_t[v]) begin bad++; $display("FAIL bit%0d_right: got=%h exp=%h", v, right2, er_t[v]); end
      total++; if (tago2 !== t) begin bad++; $display("FAIL bit%0d_tag: got=%h exp=%h", v, tago2, t); end
    end
  endtask

  task automatic run_batch(input logic [1:0] m);
    got_q.delete();
    got_tag_q.delete();
    fork
      begin
        for (int i = 0; i < feed_q.size(); i++) send2(feed_q[i], m, 4'(i));
      end
      begin
        int cyc;
        cyc = 0;
        while (got_q.size() < feed_q.size() && cyc < 30000) begin
          @(posedge clk); #1;
          ordy2 = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (ov2 && ordy2) begin
            got_q.push_back({right2, left2});
            got_tag_q.push_back(tago2);
          end
          cyc++;
        end
      end
    join
    total++;
    if (got_q.size() != feed_q.size()) begin
      bad++;
      $display("FAIL batch_count: got=%0d exp=%0d", got_q.size(), feed_q.size());
    end
    @(posedge clk); #1;
    ordy2 = 1'b1;
  endtask

  task automatic test_round_trip;
    logic [64:1] orig_q[$];
    @(posedge clk); #1;
    csb2 = 1'b0;
    feed_q.delete();
    for (int i = 0; i < 1000; i++) feed_q.push_back({$urandom(), $urandom()});
    orig_q = feed_q;
    run_batch(2'b00);
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== ip_model(orig_q[i])) begin bad++; $display("FAIL ip_blk%0d: got=%h exp=%h", i, got_q[i], ip_model(orig_q[i])); end
      total++; if (got_tag_q[i] !== 4'(i)) begin bad++; $display("FAIL ip_tag%0d: got=%h exp=%h", i, got_tag_q[i], 4'(i)); end
    end
    feed_q = got_q;
    run_batch(2'b01);
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== orig_q[i]) begin bad++; $display("FAIL rt_blk%0d: got=%h exp=%h", i, got_q[i], orig_q[i]); end
      total++; if (got_tag_q[i] !== 4'(i)) begin bad++; $display("FAIL rt_tag%0d: got=%h exp=%h", i, got_tag_q[i], 4'(i)); end
    end
  endtask

  task automatic test_back_to_back;
    int          cyc, accepts, outs, next_k;
    logic        stall_prev;
    logic [67:0] held, got, exp;
    @(posedge clk); #1;
    csb3 = 1'b0; ordy3 = 1'b0; iv3 = 1'b1;
    din3 = blk_data(0); mode3 = 2'b00; tag3 = 4'h0;
    cyc = 0; accepts = 0; outs = 0; next_k = 0; stall_prev = 1'b0; held = '0;
    exp_q.delete();
    while (outs < 16 && cyc < 300) begin
      @(negedge clk);
      got = {tago3, right3, left3};
      if (stall_prev) begin
        total++;
        if (ov3 !== 1'b1 || got !== held) begin
          bad++; $display("FAIL hold_c%0d: got=%h exp=%h ov=%b", cyc, got, held, ov3);
        end
      end
      if (ov3 && ordy3) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        total++;
        if (got !== exp) begin bad++; $display("FAIL bp_out%0d: got=%h exp=%h", outs, got, exp); end
        outs++;
      end
      if (iv3 && irdy3) begin
        exp_q.push_back({tag3, model(mode3, din3)});
        accepts++;
        next_k++;
      end
      if (cyc == 7) begin
        total++; if (accepts != 3) begin bad++; $display("FAIL bp_accepts: got=%0d exp=3", accepts); end
        total++; if (irdy3 !== 1'b0) begin bad++; $display("FAIL bp_irdy: got=%b exp=0", irdy3); end
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL bp_busy: got=%b exp=1", busy3); end
      end
      stall_prev = ov3 && !ordy3;
      held = got;
      @(posedge clk); #1;
      cyc++;
      ordy3 = (cyc >= 8) && (cyc % 2 == 0);
      iv3 = (next_k < 16);
      if (next_k < 16) begin
        din3 = blk_data(next_k); mode3 = 2'(next_k % 3); tag3 = 4'(next_k);
      end
    end
    total++; if (outs != 16) begin bad++; $display("FAIL bp_drain: got=%0d exp=16", outs); end
    iv3 = 1'b0;
  endtask

  task automatic test_chip_select;
    logic [64:1] a, b;
    int extra;
    a = 64'h0123_4567_89AB_CDEF;
    b = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    ordy2 = 1'b1; csb2 = 1'b0;
    send2(a, 2'b10, 4'h1);
    send2(b, 2'b11, 4'h2);
    csb2 = 1'b1; iv2 = 1'b1; din2 = 64'hDEAD_BEEF_0000_1111; mode2 = 2'b10; tag2 = 4'h3;
    @(negedge clk);
    total++; if (irdy2 !== 1'b0) begin bad++; $display("FAIL cs_irdy: got=%b exp=0", irdy2); end
    total++; if (ov2 !== 1'b1 || {tago2, right2, left2} !== {4'h1, a}) begin
      bad++; $display("FAIL cs_first: got=%h exp=%h", {tago2, right2, left2}, {4'h1, a});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ov2 !== 1'b1 || {tago2, right2, left2} !== {4'h2, b}) begin
      bad++; $display("FAIL cs_second: got=%h exp=%h", {tago2, right2, left2}, {4'h2, b});
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ov2) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL cs_extra: got=%0d exp=0", extra); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL cs_busy: got=%b exp=0", busy2); end
    @(posedge clk); #1;
    iv2 = 1'b0; csb2 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [64:1] d;
    int stale;
    @(posedge clk); #1;
    ordy3 = 1'b0; csb3 = 1'b0;
    for (int k = 0; k < 3; k++) send3(blk_data(40 + k), 2'b10, 4'(k));
    total++; if (ov3 !== 1'b1 || busy3 !== 1'b1) begin bad++; $display("FAIL rm_full: ov=%b busy=%b exp=1,1", ov3, busy3); end
    #2 rst = 1'b1;
    #1;
    total++; if (ov3 !== 1'b0)     begin bad++; $display("FAIL rm_ov: got=%b exp=0", ov3); end
    total++; if (busy3 !== 1'b0)   begin bad++; $display("FAIL rm_busy: got=%b exp=0", busy3); end
    total++; if (left3 !== exp_lr) begin bad++; $display("FAIL rm_left: got=%h exp=%h", left3, exp_lr); end
    @(posedge clk); #1;
    rst = 1'b0;
    ordy3 = 1'b1;
    @(negedge clk);
    total++; if (irdy3 !== 1'b1) begin bad++; $display("FAIL rm_irdy: got=%b exp=1", irdy3); end
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov3) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rm_stale: got=%0d exp=0", stale); end
    @(posedge clk); #1;
    d = 64'h1357_9BDF_2468_ACE0;
    send3(d, 2'b00, 4'hC);
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rm_lat0: got=%b exp=0", ov3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rm_lat1: got=%b exp=0", ov3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b1 || {tago3, right3, left3} !== {4'hC, ip_model(d)}) begin
      bad++; $display("FAIL rm_new: got=%h exp=%h", {tago3, right3, left3}, {4'hC, ip_model(d)});
    end
  endtask

  initial begin
    csb2 = 1'b0; iv2 = 1'b0; ordy2 = 1'b0; mode2 = 2'b00; tag2 = 4'h0; din2 = '0;
    csb3 = 1'b0; iv3 = 1'b0; ordy3 = 1'b0; mode3 = 2'b00; tag3 = 4'h0; din3 = '0;
    test_reset();
    test_single_bit();
    test_round_trip();
    test_back_to_back();
    test_chip_select();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
